// File: rtl/inst_loader.sv
// Program-load stage: parses a framed image (word count, payload, checksum) from UART byte
// strobes and writes each assembled 32-bit word into instruction BRAM port A.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_HDR   | collecting the 4-byte big-endian word count
// S_PAYLOAD| assembling payload words, one BRAM write per 4 bytes
// S_CSUM  | waiting for the checksum byte (sum8 of payload bytes)
// S_DONE  | frame accepted; loaded=1, bytes ignored until clear
// S_ERROR | frame rejected; error=1, bytes ignored until clear
module inst_loader #(
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned TIMEOUT   = 2**24
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [7:0]  data,
    input  logic        clear,
    output logic [31:0] inst_addra,
    output logic [31:0] inst_dina,
    output logic [3:0]  inst_wea,
    output logic        loaded,
    output logic        error,
    output logic [31:0] words_written
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_HDR,
        S_PAYLOAD,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic [31:0]   len;
    logic [29:0]   word_idx;
    logic [7:0]    sum8;
    logic [TW-1:0] tmo_cnt;

    logic [31:0]   word_in;
    logic          last_byte;
    logic          started;
    logic          tmo_run;
    logic          tmo_hit;
    logic          wr_now;

    assign word_in   = {shift, data};
    assign last_byte = (byte_cnt == 2'd3);
    // The frame counts as started once any header byte has arrived.
    assign started   = (state != S_HDR) || (byte_cnt != 2'd0);
    assign tmo_run   = started && (state inside {S_HDR, S_PAYLOAD, S_CSUM});
    assign tmo_hit   = (TIMEOUT != 0) && tmo_run && !en && (tmo_cnt == TMO_LAST);
    assign wr_now    = en && (state == S_PAYLOAD) && last_byte;

    assign loaded = (state == S_DONE);
    assign error  = (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_HDR;
        end else if (en) begin
            case (state)
                S_HDR: begin
                    if (last_byte) begin
                        if (word_in > MAX_WORDS) begin
                            state_nxt = S_ERROR;
                        end else if (word_in == 32'd0) begin
                            state_nxt = S_CSUM;
                        end else begin
                            state_nxt = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (last_byte && (words_written + 32'd1 == len)) begin
                        state_nxt = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_nxt = (data == sum8) ? S_DONE : S_ERROR;
                end
                default: state_nxt = state;
            endcase
        end else if (tmo_hit) begin
            state_nxt = S_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt      <= 2'd0;
            shift         <= 24'd0;
            len           <= 32'd0;
            word_idx      <= 30'd0;
            sum8          <= 8'd0;
            tmo_cnt       <= '0;
            inst_addra    <= 32'd0;
            inst_dina     <= 32'd0;
            inst_wea      <= 4'h0;
            words_written <= 32'd0;
        end else begin
            inst_wea <= 4'h0;
            if (clear) begin
                byte_cnt      <= 2'd0;
                shift         <= 24'd0;
                len           <= 32'd0;
                word_idx      <= 30'd0;
                sum8          <= 8'd0;
                tmo_cnt       <= '0;
                words_written <= 32'd0;
            end else begin
                if (en) begin
                    tmo_cnt <= '0;
                end else if (tmo_run) begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
                if (en && (state == S_HDR || state == S_PAYLOAD)) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    shift    <= word_in[23:0];
                end
                if (en && state == S_HDR && last_byte) begin
                    len <= word_in;
                end
                if (en && state == S_PAYLOAD) begin
                    sum8 <= sum8 + data;
                end
                // Registered write pulse keeps back-to-back byte strobes legal.
                if (wr_now) begin
                    inst_wea      <= 4'hF;
                    inst_addra    <= {word_idx, 2'b00};
                    inst_dina     <= word_in;
                    word_idx      <= word_idx + 30'd1;
                    words_written <= words_written + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: frames are driven from a word list while expected BRAM
// writes go into a scoreboard that a negedge monitor drains.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        clear = 1'b0;
    logic [31:0] inst_addra;
    logic [31:0] inst_dina;
    logic [3:0]  inst_wea;
    logic        loaded;
    logic        error;
    logic [31:0] words_written;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] word_q[$];

    inst_loader #(
        .MAX_WORDS(4096),
        .TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .data         (data),
        .clear        (clear),
        .inst_addra   (inst_addra),
        .inst_dina    (inst_dina),
        .inst_wea     (inst_wea),
        .loaded       (loaded),
        .error        (error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (inst_wea != 4'h0) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", 32'(inst_wea), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", inst_addra, e.addr);
                chk("wr_data", inst_dina, e.data);
                chk("wr_wea", 32'(inst_wea), 32'hF);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] b);
        en   = 1'b1;
        data = b;
        @(negedge clk);
        en   = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Sends word_q as a frame; csum_xor corrupts the checksum byte when non-zero.
    task automatic send_frame(input int gap, input logic [7:0] csum_xor);
        logic [7:0]  sum;
        logic [7:0]  by;
        logic [31:0] len;
        logic [31:0] cur;
        sum = 8'h00;
        len = 32'(word_q.size());
        for (int i = 0; i < 4; i++) begin
            drive(len[31-8*i -: 8]);
            idle(gap);
        end
        for (int w = 0; w < word_q.size(); w++) begin
            cur = word_q[w];
            for (int b = 0; b < 4; b++) begin
                by  = cur[31-8*b -: 8];
                sum = sum + by;
                if (b == 3) sb.push_back('{addr: 32'(w * 4), data: cur});
                drive(by);
                idle(gap);
            end
        end
        drive(sum ^ csum_xor);
    endtask

    task automatic check_outcome(input string tag, input logic exp_loaded, input logic exp_error,
                                 input int exp_words);
        idle(3);
        chk({tag, "_loaded"}, 32'(loaded), 32'(exp_loaded));
        chk({tag, "_error"}, 32'(error), 32'(exp_error));
        chk({tag, "_words"}, words_written, 32'(exp_words));
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        idle(3);
        rstn = 1'b1;
        idle(1);
        chk("rst_addra", inst_addra, 32'h0);
        chk("rst_dina", inst_dina, 32'h0);
        chk("rst_wea", 32'(inst_wea), 32'h0);
        chk("rst_loaded", 32'(loaded), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_words", words_written, 32'h0);

        // T1: two words, checksum 0x38
        word_q = '{32'h12345678, 32'h9ABCDEF0};
        send_frame(1, 8'h00);
        check_outcome("t1", 1'b1, 1'b0, 2);

        // T2: checksum 0x39
        pulse_clear();
        send_frame(2, 8'h01);
        check_outcome("t2", 1'b0, 1'b1, 2);

        // T3: empty frame, then oversize header
        pulse_clear();
        word_q.delete();
        send_frame(0, 8'h00);
        check_outcome("t3_empty", 1'b1, 1'b0, 0);
        pulse_clear();
        drive(8'h00);
        drive(8'h00);
        drive(8'h10);
        drive(8'h01);
        chk("t3_big_error_next", 32'(error), 32'h1);
        drive(8'h11);
        drive(8'h22);
        drive(8'h33);
        drive(8'h44);
        check_outcome("t3_big", 1'b0, 1'b1, 0);

        // T4: back-to-back bytes, three words
        pulse_clear();
        word_q = '{32'hCAFEBABE, 32'h00FF00FF, 32'hDEADBEEF};
        send_frame(0, 8'h00);
        check_outcome("t4", 1'b1, 1'b0, 3);

        // T5: timeout boundary
        pulse_clear();
        idle(40);
        chk("t5_idle_hdr_error", 32'(error), 32'h0);
        drive(8'h00);
        drive(8'h00);
        idle(15);
        chk("t5_idle15_error", 32'(error), 32'h0);
        idle(1);
        chk("t5_idle16_error", 32'(error), 32'h1);
        chk("t5_words", words_written, 32'h0);

        // T6: clear+en in DONE drops the byte
        pulse_clear();
        word_q = '{32'h12345678, 32'h9ABCDEF0};
        send_frame(0, 8'h00);
        check_outcome("t6_first", 1'b1, 1'b0, 2);
        clear = 1'b1;
        en    = 1'b1;
        data  = 8'hAA;
        @(negedge clk);
        clear = 1'b0;
        en    = 1'b0;
        chk("t6_clr_loaded", 32'(loaded), 32'h0);
        chk("t6_clr_error", 32'(error), 32'h0);
        chk("t6_clr_words", words_written, 32'h0);
        send_frame(1, 8'h00);
        check_outcome("t6_second", 1'b1, 1'b0, 2);

        // Reset mid-payload
        pulse_clear();
        drive(8'h00);
        drive(8'h00);
        drive(8'h00);
        drive(8'h02);
        drive(8'h12);
        drive(8'h34);
        drive(8'h56);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_addra", inst_addra, 32'h0);
        chk("rst_mid_dina", inst_dina, 32'h0);
        chk("rst_mid_wea", 32'(inst_wea), 32'h0);
        chk("rst_mid_loaded", 32'(loaded), 32'h0);
        chk("rst_mid_error", 32'(error), 32'h0);
        chk("rst_mid_words", words_written, 32'h0);
        rstn = 1'b1;
        idle(3);
        chk("rst_mid_sb", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
